// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the MEM-stage load/store unit and the data memory.
// The master drives the request side; the slave returns read data and ack.
interface mem_lsu_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    modport master (
        output dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_ack
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_ack
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one data-bus transaction per load/store, load
// data formatting, pipeline stall request and address-error detection.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [31:0] mem_pc,
    input  logic        mem_hold,
    mem_lsu_if.master   dbus,
    output logic        stallreq,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] badvaddr
);
    localparam logic [7:0] ALU_OP_LB  = 8'b1110_0000;
    localparam logic [7:0] ALU_OP_LH  = 8'b1110_0001;
    localparam logic [7:0] ALU_OP_LW  = 8'b1110_0011;
    localparam logic [7:0] ALU_OP_LBU = 8'b1110_0100;
    localparam logic [7:0] ALU_OP_LHU = 8'b1110_0101;
    localparam logic [7:0] ALU_OP_SB  = 8'b1110_1000;
    localparam logic [7:0] ALU_OP_SH  = 8'b1110_1001;
    localparam logic [7:0] ALU_OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_req;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_ldbuf;
    logic [7:0]  r_op;
    logic [1:0]  r_alo;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misaligned;
    logic        w_start;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;
    logic        w_unused_pc;

    // The PC travels with the instruction for later exception reporting only.
    assign w_unused_pc = ^mem_pc;

    assign w_is_load  = (mem_aluop == ALU_OP_LB) || (mem_aluop == ALU_OP_LBU) ||
                        (mem_aluop == ALU_OP_LH) || (mem_aluop == ALU_OP_LHU) ||
                        (mem_aluop == ALU_OP_LW);
    assign w_is_store = (mem_aluop == ALU_OP_SB) || (mem_aluop == ALU_OP_SH) ||
                        (mem_aluop == ALU_OP_SW);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_is_word  = (mem_aluop == ALU_OP_LW) || (mem_aluop == ALU_OP_SW);
    assign w_is_half  = (mem_aluop == ALU_OP_LH) || (mem_aluop == ALU_OP_LHU) ||
                        (mem_aluop == ALU_OP_SH);
    assign w_misaligned = (w_is_word && (mem_mem_addr[1:0] != 2'b00)) ||
                          (w_is_half && mem_mem_addr[0]);
    assign w_start = (r_state == ST_IDLE) && w_is_mem && !w_misaligned;

    // Byte-lane enables and lane-replicated store data for the pending access.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = mem_reg2;
        if (w_is_half) begin
            w_sel   = 4'b0011 << {mem_mem_addr[1], 1'b0};
            w_wdata = {2{mem_reg2[15:0]}};
        end else if (!w_is_word) begin
            w_sel   = 4'b0001 << mem_mem_addr[1:0];
            w_wdata = {4{mem_reg2[7:0]}};
        end
    end

    // Extract and extend the addressed lane of the returned word, using the
    // op and address latched at request time.
    always_comb begin
        w_byte     = dbus.dbus_rdata[7:0];
        w_half     = r_alo[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
        w_load_fmt = dbus.dbus_rdata;
        case (r_alo)
            2'd1:    w_byte = dbus.dbus_rdata[15:8];
            2'd2:    w_byte = dbus.dbus_rdata[23:16];
            2'd3:    w_byte = dbus.dbus_rdata[31:24];
            default: w_byte = dbus.dbus_rdata[7:0];
        endcase
        case (r_op)
            ALU_OP_LB:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            ALU_OP_LBU: w_load_fmt = {24'h000000, w_byte};
            ALU_OP_LH:  w_load_fmt = {{16{w_half[15]}}, w_half};
            ALU_OP_LHU: w_load_fmt = {16'h0000, w_half};
            default:    w_load_fmt = dbus.dbus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    // Bus request registers and load buffer; reset drops the request at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_ldbuf <= 32'h0;
            r_op    <= 8'h00;
            r_alo   <= 2'b00;
        end else begin
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= w_is_store;
                r_sel   <= w_sel;
                r_addr  <= {mem_mem_addr[31:2], 2'b00};
                r_wdata <= w_wdata;
                r_op    <= mem_aluop;
                r_alo   <= mem_mem_addr[1:0];
            end
            if ((r_state == ST_WAIT) && dbus.dbus_ack) begin
                r_req   <= 1'b0;
                r_ldbuf <= w_load_fmt;
            end
        end
    end

    // Next state, stall request, exceptions and MEM/WB outputs.
    always_comb begin
        w_state_next = r_state;
        stallreq     = 1'b0;
        exc_adel     = 1'b0;
        exc_ades     = 1'b0;
        badvaddr     = 32'h0;
        wb_wd        = mem_wd;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    wb_wreg = 1'b0;
                    if (w_misaligned) begin
                        exc_adel = w_is_load && rst;
                        exc_ades = w_is_store && rst;
                        badvaddr = mem_mem_addr;
                    end else begin
                        stallreq     = rst;
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stallreq = rst;
                wb_wreg  = 1'b0;
                if (dbus.dbus_ack) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (r_we) wb_wreg  = 1'b0;
                else      wb_wdata = r_ldbuf;
                if (!mem_hold) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign dbus.dbus_req   = r_req;
    assign dbus.dbus_we    = r_we;
    assign dbus.dbus_sel   = r_sel;
    assign dbus.dbus_addr  = r_addr;
    assign dbus.dbus_wdata = r_wdata;
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized load/store
// traffic checked against an arithmetic reference model.
module tb_mem_lsu;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  mem_wd = 5'd0;
    logic        mem_wreg = 1'b0;
    logic [31:0] mem_wdata = 32'h0;
    logic [7:0]  mem_aluop = 8'h00;
    logic [31:0] mem_mem_addr = 32'h0;
    logic [31:0] mem_reg2 = 32'h0;
    logic [31:0] mem_pc = 32'h0;
    logic        mem_hold = 1'b0;
    logic        stallreq;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] badvaddr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_lsu_if u_if ();

    mem_lsu u_dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .mem_pc       (mem_pc),
        .mem_hold     (mem_hold),
        .dbus         (u_if),
        .stallreq     (stallreq),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .exc_adel     (exc_adel),
        .exc_ades     (exc_ades),
        .badvaddr     (badvaddr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes, from the opcode.
    function automatic int op_size(input logic [7:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction

    function automatic bit op_is_load(input logic [7:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
    endfunction

    function automatic bit op_is_store(input logic [7:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        int unsigned ofs = addr % 4;
        if (sz == 4) return 4'd15;
        if (sz == 2) return 4'(3 << ofs);
        return 4'(1 << ofs);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] reg2);
        int sz = op_size(op);
        if (sz == 4) return reg2;
        if (sz == 2) return (reg2 % 65536) * 32'h0001_0001;
        return (reg2 % 256) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] b = (rdata >> (8 * (addr % 4))) % 256;
        logic [31:0] h = (rdata >> (16 * ((addr % 4) / 2))) % 65536;
        case (op)
            OP_LB:   return (b >= 128) ? b - 32'd256 : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32768) ? h - 32'd65536 : h;
            OP_LHU:  return h;
            default: return rdata;
        endcase
    endfunction

    // One instruction through the MEM stage; ends just after the edge that
    // returns the unit to IDLE (or the single cycle of a non-bus op).
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rdata, input int waits, input int hold);
        bit          ld  = op_is_load(op);
        bit          st  = op_is_store(op);
        bit          mis = (addr % op_size(op)) != 0;
        logic [31:0] exp_ld = exp_load(op, addr, rdata);
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        mem_wd       = 5'($urandom_range(1, 31));
        mem_wreg     = 1'b1;
        mem_wdata    = $urandom;
        mem_pc       = $urandom;
        mem_hold     = 1'b0;
        #1;
        if (!ld && !st) begin
            chk("pass_wd", 32'(wb_wd), 32'(mem_wd));
            chk("pass_wreg", 32'(wb_wreg), 32'd1);
            chk("pass_wdata", wb_wdata, mem_wdata);
            chk("pass_stall", 32'(stallreq), 32'd0);
            step();
            chk("pass_noreq", 32'(u_if.dbus_req), 32'd0);
            $display("op=%h addr=%h non-memory pass-through", op, addr);
            return;
        end
        if (mis) begin
            chk("mis_adel", 32'(exc_adel), 32'(ld));
            chk("mis_ades", 32'(exc_ades), 32'(st));
            chk("mis_badvaddr", badvaddr, addr);
            chk("mis_stall", 32'(stallreq), 32'd0);
            chk("mis_wreg", 32'(wb_wreg), 32'd0);
            step();
            chk("mis_noreq", 32'(u_if.dbus_req), 32'd0);
            $display("op=%h addr=%h misaligned", op, addr);
            return;
        end
        chk("idle_stall", 32'(stallreq), 32'd1);
        chk("idle_exc", 32'({exc_adel, exc_ades}), 32'd0);
        step();
        chk("req", 32'(u_if.dbus_req), 32'd1);
        chk("we", 32'(u_if.dbus_we), 32'(st));
        chk("sel", 32'(u_if.dbus_sel), 32'(exp_sel(op, addr)));
        chk("addr", u_if.dbus_addr, addr - addr % 4);
        chk("wdata", u_if.dbus_wdata, exp_wdata(op, reg2));
        for (int k = 0; k <= waits; k++) begin
            u_if.dbus_ack   = (k == waits);
            u_if.dbus_rdata = (k == waits) ? rdata : $urandom;
            #1;
            chk("wait_stall", 32'(stallreq), 32'd1);
            chk("wait_req", 32'(u_if.dbus_req), 32'd1);
            step();
        end
        u_if.dbus_ack   = 1'b0;
        u_if.dbus_rdata = $urandom;
        #1;
        chk("done_req", 32'(u_if.dbus_req), 32'd0);
        chk("done_stall", 32'(stallreq), 32'd0);
        chk("done_wreg", 32'(wb_wreg), 32'(ld));
        if (ld) begin
            chk("done_wd", 32'(wb_wd), 32'(mem_wd));
            chk("done_ldata", wb_wdata, exp_ld);
        end
        for (int h = 0; h < hold; h++) begin
            mem_hold        = 1'b1;
            u_if.dbus_ack   = 1'b1;
            step();
            u_if.dbus_ack   = 1'b0;
            #1;
            chk("hold_req", 32'(u_if.dbus_req), 32'd0);
            chk("hold_stall", 32'(stallreq), 32'd0);
            if (ld) chk("hold_ldata", wb_wdata, exp_ld);
        end
        mem_hold = 1'b0;
        step();
        #1;
        chk("back_idle_stall", 32'(stallreq), 32'd1);
        $display("op=%h addr=%h reg2=%h rdata=%h waits=%0d hold=%0d ld=%h",
                 op, addr, reg2, rdata, waits, hold, exp_ld);
    endtask

    initial begin
        logic [7:0]  ops [10];
        logic [7:0]  rop;
        logic [31:0] raddr;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, OP_ADD, OP_LW};
        u_if.dbus_ack   = 1'b0;
        u_if.dbus_rdata = 32'h0;

        // Reset: combinational flags suppressed, bus registers cleared.
        mem_aluop    = OP_LW;
        mem_mem_addr = 32'h101;
        #2;
        chk("rst_adel", 32'(exc_adel), 32'd0);
        mem_mem_addr = 32'h100;
        #1;
        chk("rst_stall", 32'(stallreq), 32'd0);
        step();
        chk("rst_req", 32'(u_if.dbus_req), 32'd0);
        chk("rst_we", 32'(u_if.dbus_we), 32'd0);
        chk("rst_sel", 32'(u_if.dbus_sel), 32'd0);
        chk("rst_addr", u_if.dbus_addr, 32'd0);
        chk("rst_wdata", u_if.dbus_wdata, 32'd0);
        mem_aluop = OP_ADD;
        step();
        rst = 1'b1;
        $display("reset released");

        // Directed cases.
        do_mem(OP_ADD, 32'h0, 32'h0, 32'h0, 0, 0);
        do_mem(OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 1, 0);
        do_mem(OP_LB,  32'h103, 32'h0, 32'h80123456, 0, 0);
        do_mem(OP_LBU, 32'h103, 32'h0, 32'h80123456, 0, 0);
        do_mem(OP_SH,  32'h202, 32'h1234ABCD, 32'h0, 0, 0);
        do_mem(OP_LW,  32'h101, 32'h0, 32'h0, 0, 0);
        do_mem(OP_SW,  32'h102, 32'h0, 32'h0, 0, 0);
        do_mem(OP_LH,  32'h201, 32'h0, 32'h0, 0, 0);
        do_mem(OP_LH,  32'h302, 32'h0, 32'h8001_7FFF, 2, 2);
        do_mem(OP_LHU, 32'h302, 32'h0, 32'h8001_7FFF, 0, 0);

        // Reset asserted during WAIT: request drops asynchronously.
        mem_aluop    = OP_LW;
        mem_mem_addr = 32'h300;
        #1;
        chk("rw_idle_stall", 32'(stallreq), 32'd1);
        step();
        chk("rw_req", 32'(u_if.dbus_req), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rw_async_req", 32'(u_if.dbus_req), 32'd0);
        chk("rw_stall", 32'(stallreq), 32'd0);
        u_if.dbus_ack   = 1'b1;
        u_if.dbus_rdata = 32'hCAFEF00D;
        step();
        u_if.dbus_ack = 1'b0;
        mem_aluop     = OP_ADD;
        mem_wd        = 5'd7;
        mem_wreg      = 1'b1;
        mem_wdata     = 32'h5555AAAA;
        step();
        rst = 1'b1;
        #1;
        chk("rw_pass_wdata", wb_wdata, 32'h5555AAAA);
        chk("rw_pass_wd", 32'(wb_wd), 32'd7);
        chk("rw_pass_wreg", 32'(wb_wreg), 32'd1);
        u_if.dbus_ack = 1'b1;
        step();
        u_if.dbus_ack = 1'b0;
        chk("rw_ack_ignored", 32'(u_if.dbus_req), 32'd0);
        chk("rw_pass_wdata2", wb_wdata, 32'h5555AAAA);
        $display("reset during WAIT handled");
        do_mem(OP_SB, 32'h405, 32'h000000A5, 32'h0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            rop   = ops[$urandom_range(0, 9)];
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) raddr = raddr - raddr % 4 + 32'(2 * $urandom_range(0, 1) * ((op_size(rop) == 2) ? 1 : 0));
            do_mem(rop, raddr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

MEM-stage load/store unit of the five-stage MIPS core. Consumes the EX/MEM pipeline register outputs (destination, write data, ALU op, effective address, store operand, PC), runs one data-bus transaction per load/store over a req/ack handshake, formats load data, and drives the MEM/WB inputs. While a transaction is outstanding it holds the pipeline through `stallreq`. It also flags misaligned accesses.

## Interface
- No parameters; widths from `defines.v`: RegBus 32, RegAddrBus 5, AluOpBus 8, WriteBus 1.
- `clk`  in  1  core clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_wd`, `mem_wreg`, `mem_wdata`  in  5/1/32  destination register, write enable, and EX result from EX/MEM.
- `mem_aluop`  in  8  operation; `ALU_OP_LB/LBU/LH/LHU/LW/SB/SH/SW` encodings from `defines.v`.
- `mem_mem_addr`  in  32  effective address.
- `mem_reg2`  in  32  store operand.
- `mem_pc`  in  32  instruction PC.
- `mem_hold`  in  1  `stall[4]` from the stall controller; MEM/WB is not advancing this cycle.
- `dbus_req`, `dbus_we`  out  1/1  request and write strobe (registered).
- `dbus_sel`  out  4  byte-lane enables; lane 0 is bits [7:0] (registered).
- `dbus_addr`, `dbus_wdata`  out  32/32  word address {addr[31:2],2'b00} and store data (registered).
- `dbus_rdata`  in  32  read data; valid in the cycle `dbus_ack`=1.
- `dbus_ack`  in  1  one-cycle completion pulse.
- `stallreq`  out  1  stall request to the stall controller (combinational).
- `wb_wd`, `wb_wreg`, `wb_wdata`  out  5/1/32  to MEM/WB.
- `exc_adel`, `exc_ades`, `badvaddr`  out  1/1/32  load/store address-error flags and faulting address (combinational).

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Non-memory op in IDLE: `wb_*` = `mem_*` pass-through; `stallreq`=0; no bus activity.
- Alignment: LW/SW need addr[1:0]=0. LH/LHU/SH need addr[0]=0. Byte ops are always aligned.
- Misaligned op in IDLE:
  - No request is issued; `stallreq`=0; `wb_wreg`=0.
  - `exc_adel` (loads) or `exc_ades` (stores) =1 for that cycle, with `badvaddr`=`mem_mem_addr`.
- Aligned op in IDLE:
  - `stallreq`=1 combinationally.
  - On the next edge: load `dbus_*`, set `dbus_req`=1, go to WAIT.
- Lane select and store data:
  - Byte: sel=4'b0001<<addr[1:0]; wdata={4{reg2[7:0]}}.
  - Half: sel=4'b0011<<{addr[1],1'b0}; wdata={2{reg2[15:0]}}.
  - Word: sel=4'b1111; wdata=reg2.
  - `dbus_we`=1 for stores, 0 for loads.
- WAIT:
  - `stallreq`=1; `dbus_*` held stable.
  - When `dbus_ack`=1: latch the formatted load data into `ldbuf`, drop `dbus_req` at the edge, go to DONE.
- Load formatting:
  - LB/LBU: byte lane addr[1:0], sign-extended / zero-extended.
  - LH/LHU: half lane addr[1], sign-extended / zero-extended.
  - LW: full word.
- DONE:
  - `stallreq`=0.
  - Loads: `wb_wdata`=`ldbuf`, `wb_wreg`=`mem_wreg`. Stores: `wb_wreg`=0.
  - `mem_hold`=1: stay in DONE. `mem_hold`=0: go to IDLE at the edge.
- `dbus_ack` in IDLE or DONE is ignored.

## Timing
- Reset values: `dbus_req`/`dbus_we`=0, `dbus_sel`=0, `dbus_addr`/`dbus_wdata`=0, `ldbuf`=0, state IDLE. `stallreq`, `exc_*`=0 while `rst`=0.
- `rst` asserted mid-transaction: the request drops immediately, asynchronously. The bus abandons the transaction; no ack is expected.
- Minimum latency per load/store: 3 cycles (IDLE detect, WAIT with same-cycle ack, DONE). Each extra wait cycle on `dbus_ack` adds one cycle.
- `stallreq` is high from the IDLE detect cycle through the ack cycle inclusive, and low in DONE.
- At most one outstanding transaction. Back-to-back memory ops re-enter IDLE between transactions, so the second `dbus_req` rises 3 cycles after the first ack.

## Test plan
- LW addr 0x100, `dbus_rdata`=0xDEADBEEF, ack 2 cycles after req -> `dbus_sel`=4'hF, `dbus_addr`=0x100; `stallreq` high 3 cycles; in DONE `wb_wdata`=0xDEADBEEF.
- LB addr 0x103 / LBU addr 0x103, rdata=0x80xxxxxx -> sel 4'b1000; `wb_wdata`=0xFFFFFF80 / 0x00000080.
- SH addr 0x202, reg2=0x1234ABCD, ack in the first WAIT cycle -> `dbus_we`=1, sel 4'b1100, wdata=0xABCDABCD, `wb_wreg`=0; total latency 3 cycles.
- LW addr 0x101 -> `exc_adel`=1, `badvaddr`=0x101, `dbus_req` never rises, `stallreq`=0.
- `rst` low during WAIT, then ack pulses -> `dbus_req`=0 immediately; ack ignored; after release, state IDLE and `wb_*` pass-through.
- DONE with `mem_hold`=1 for 2 cycles -> stays in DONE, `ldbuf` stable, no new request; IDLE on the first cycle with `mem_hold`=0.
